// File: rtl/bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_pkg : shared types and constants for the sequential bin-to-BCD path  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'h9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Elaboration-time 10**n; DIGITS <= 6 keeps this well inside 32 bits.
   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_digit_adj : double-dabble digit correction, adds 3 when digit >= 5   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule
`default_nettype wire

// File: rtl/module_bin_to_bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | module_bin_to_bcd_seq : sequential shift-and-add-3 binary-to-BCD         |
// | converter, one input bit per cycle. Optional macro BIN_TO_BCD_BLANK_EN   |
// | builds the registered leading-zero blank mask.                           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module module_bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 12,
   parameter int DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  valid_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  ovf_o,
   output logic [DIGITS-1:0]     blank_o
);

   localparam int          c_SCR_W   = (DIGITS + 1) * BCD_DIGIT_W;
   localparam int          c_CNT_W   = $clog2(WIDTH + 1);
   localparam logic [31:0] c_OVF_LIM = 32'(pow10(DIGITS));

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       shift_q, shift_d;
   logic [c_SCR_W-1:0]     scratch_q, scratch_d;
   logic [c_SCR_W-1:0]     adj_scratch;
   logic [c_CNT_W-1:0]     cnt_q, cnt_d;
   logic                   ovf_pend_q, ovf_pend_d;
   logic [4*DIGITS-1:0]    bcd_q, bcd_d;
   logic                   ovf_q, ovf_d;
   logic                   valid_q, valid_d;

   for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (adj_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = SHIFT;
         SHIFT:   if (cnt_q == c_CNT_W'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == SHIFT);
   end

   always_comb begin
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               shift_d    = bin_i;
               scratch_d  = '0;
               cnt_d      = c_CNT_W'(WIDTH);
               ovf_pend_d = (32'(bin_i) >= c_OVF_LIM);
            end
         end
         SHIFT: begin
            {scratch_d, shift_d} = {adj_scratch, shift_q} << 1;
            cnt_d                = cnt_q - c_CNT_W'(1);
         end
         DONE: begin
            valid_d = 1'b1;
            ovf_d   = ovf_pend_q;
            bcd_d   = ovf_pend_q ? {DIGITS{BCD_NINE}} : scratch_q[4*DIGITS-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign valid_o = valid_q;
   assign bcd_o   = bcd_q;
   assign ovf_o   = ovf_q;

`ifdef BIN_TO_BCD_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d;
   logic              zero_above;

   // Walk down from the top digit; a digit blanks only while everything above it is zero.
   always_comb begin
      blank_d    = blank_q;
      zero_above = 1'b1;
      if (state_q == DONE) begin
         blank_d = '0;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (scratch_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_d[i] = zero_above && !ovf_pend_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign blank_o = blank_q;
`else
   assign blank_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_module_bin_to_bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_module_bin_to_bcd_seq : scoreboard bench for two converter instances  |
// | (WIDTH=12 and WIDTH=14, both DIGITS=4). Revision : 1.0                   |
// +--------------------------------------------------------------------------+
module tb_module_bin_to_bcd_seq;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      logic [3:0]  blank;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start12 = 1'b0, start14 = 1'b0;
   logic [11:0] bin12 = '0;
   logic [13:0] bin14 = '0;
   logic        busy12, valid12, ovf12, busy14, valid14, ovf14;
   logic [15:0] bcd12, bcd14;
   logic [3:0]  blank12, blank14;

   exp_t q12[$];
   exp_t q14[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_mis = 0;
   int   busy12_tot = 0;

   always #5 clk = ~clk;

   module_bin_to_bcd_seq #(.WIDTH(12), .DIGITS(4)) u_dut12 (
      .clk_i(clk), .rst_i(rst), .start_i(start12), .bin_i(bin12),
      .busy_o(busy12), .valid_o(valid12), .bcd_o(bcd12), .ovf_o(ovf12), .blank_o(blank12)
   );

   module_bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) u_dut14 (
      .clk_i(clk), .rst_i(rst), .start_i(start14), .bin_i(bin14),
      .busy_o(busy14), .valid_o(valid14), .bcd_o(bcd14), .ovf_o(ovf14), .blank_o(blank14)
   );

   function automatic logic [15:0] m_bcd(input int v);
      logic [15:0] res;
      int r;
      if (v >= 10000) return 16'h9999;
      res = '0;
      r = v;
      for (int i = 0; i < 4; i++) begin
         res[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return res;
   endfunction

   function automatic logic [3:0] m_blank(input int v);
      logic [3:0] b;
      b = '0;
`ifdef BIN_TO_BCD_BLANK_EN
      if (v < 10)   b[1] = 1'b1;
      if (v < 100)  b[2] = 1'b1;
      if (v < 1000) b[3] = 1'b1;
`endif
      if (v >= 10000) b = '0;
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mon_one(input string nm, input logic v, input logic [15:0] bcd,
                          input logic ovf, input logic [3:0] blank, inout exp_t q[$]);
      exp_t e;
      if (v) begin
         if (q.size() == 0) begin
            chk({nm, "_spurious_valid"}, 32'(v), 32'd0);
         end else begin
            e = q.pop_front();
            chk({nm, "_bcd"},   32'(bcd),   32'(e.bcd));
            chk({nm, "_ovf"},   32'(ovf),   32'(e.ovf));
            chk({nm, "_blank"}, 32'(blank), 32'(e.blank));
            chk({nm, "_valid_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
         chk({nm, "_valid_missing"}, 32'(v), 32'd1);
         void'(q.pop_front());
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon_one("d12", valid12, bcd12, ovf12, blank12, q12);
      mon_one("d14", valid14, bcd14, ovf14, blank14, q14);
      if (busy12) busy12_tot++;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic go12(input int v, input bit push);
      exp_t e;
      start12 = 1'b1;
      bin12   = 12'(v);
      if (push) begin
         e.bcd = m_bcd(v); e.ovf = (v >= 10000); e.blank = m_blank(v); e.cyc = cyc + 14;
         q12.push_back(e);
      end
      tick();
      start12 = 1'b0;
      bin12   = 12'($urandom);
   endtask

   task automatic go14(input int v);
      exp_t e;
      start14 = 1'b1;
      bin14   = 14'(v);
      e.bcd = m_bcd(v); e.ovf = (v >= 10000); e.blank = m_blank(v); e.cyc = cyc + 16;
      q14.push_back(e);
      tick();
      start14 = 1'b0;
      bin14   = 14'($urandom);
   endtask

   task automatic run12(input int v);
      go12(v, 1'b1);
      repeat (13) tick();
   endtask

   task automatic run14(input int v);
      go14(v);
      repeat (15) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      @(posedge clk); #1;
      repeat (2) tick();
      chk("rst_busy",  32'(busy12),  32'd0);
      chk("rst_valid", 32'(valid12), 32'd0);
      chk("rst_bcd",   32'(bcd12),   32'd0);
      chk("rst_ovf",   32'(ovf12),   32'd0);
      chk("rst_blank", 32'(blank12), 32'd0);
      rst = 1'b0;
      tick();

      run12(0);
      b0 = busy12_tot;
      run12(4095);
      chk("busy_cycles_4095", 32'(busy12_tot - b0), 32'd12);

      // Second start while busy must be dropped; third start lands in the valid cycle.
      go12(42, 1'b1);
      tick();
      start12 = 1'b1; bin12 = 12'd7;
      tick();
      start12 = 1'b0;
      repeat (11) tick();
      run12(7);

      // Abort 1234 five cycles into the conversion.
      go12(1234, 1'b0);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_bcd",   32'(bcd12),   32'd0);
      chk("abort_busy",  32'(busy12),  32'd0);
      chk("abort_valid", 32'(valid12), 32'd0);
      repeat (16) tick();
      run12(1234);

      run14(9999);
      run14(10000);
      run14(16383);
      run14(0);
      run14(5);
      for (int i = 0; i < 100; i++) run14(int'($urandom_range(0, 16383)));

      for (int i = 0; i < 1000; i++) run12(int'($urandom_range(0, 4095)));

      repeat (20) tick();
      chk("d12_queue_drained", 32'(q12.size()), 32'd0);
      chk("d14_queue_drained", 32'(q14.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/module_bin_to_bcd_seq.md
Name: module_bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It converts one value per request through a start/valid handshake, taking one cycle per input bit.
It replaces the single-cycle divide/modulo converter in the display path for wide operands, where dividers do not meet timing.
Its output feeds the 7-segment multiplexer.

Parameters:
WIDTH, 12, bit width of the binary input (1..20).
DIGITS, 4, number of BCD digits produced (1..6); bcd_o width is 4*DIGITS.

Ports:
clk_i  input  1  system clock; all logic on the rising edge.
rst_i  input  1  synchronous reset, active-high.
start_i  input  1  conversion request; sampled only in IDLE.
bin_i  input  WIDTH  unsigned binary operand; captured on the accepted start_i edge.
busy_o  output  1  high while a conversion is in progress (state SHIFT).
valid_o  output  1  one-cycle pulse; bcd_o/ovf_o updated in this cycle.
bcd_o  output  4*DIGITS  result; digit 0 (units) at [3:0]; holds its value between conversions.
ovf_o  output  1  operand >= 10**DIGITS; qualified by valid_o and held with bcd_o.
blank_o  output  DIGITS  leading-zero blank mask (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i; it is only sampled on the rising edge of clk_i.
- Reset values: state=IDLE, busy_o=0, valid_o=0, bcd_o=0, ovf_o=0, blank_o=0; internal shift and scratch registers cleared.
- Reset asserted mid-conversion aborts the conversion. No valid_o is issued, and bcd_o returns to 0 (not the previous result).
- IDLE:
  - start_i=1 latches bin_i into the shift register and clears the scratch BCD register (DIGITS+1 digits; the extra digit is used for overflow detection).
  - Loads bit counter = WIDTH, computes ovf flag = (bin_i >= 10**DIGITS) using an elaboration-time constant, and moves to SHIFT.
- SHIFT, each cycle:
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, shift} shifts left by 1; the MSB of shift enters scratch bit 0.
  - The counter decrements. When counter reaches 1 on this edge, the next state is DONE.
- DONE, one cycle:
  - bcd_o <= low DIGITS scratch digits, or all digits 4'h9 if ovf (saturation).
  - ovf_o <= ovf; valid_o=1; return to IDLE.
- Latency: start_i sampled on edge N gives valid_o high for exactly the cycle after edge N+WIDTH+1.
  - Throughput is one conversion per WIDTH+2 cycles.
- start_i while busy or in DONE is ignored (not queued). start_i in the cycle valid_o is high is accepted, since the FSM is already in IDLE.
- bin_i changes after acceptance have no effect.
- WIDTH such that 2**WIDTH-1 < 10**DIGITS means ovf_o is never set. This is legal, not an error.
- Digit arithmetic is 4-bit unsigned; add-3 never carries out of a digit by construction.

Optional Feature:
Macro BIN_TO_BCD_BLANK_EN.
- Defined: in DONE, blank_o[i]=1 for every digit i>0 such that digits i..DIGITS-1 are all zero. blank_o[0] is never set. Registered and updated with valid_o. Under ovf, blank_o=0.
- Undefined: blank_o is tied to 0 and the mask logic is not built. The port list is unchanged.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W=4.
  - State encoding typedef (IDLE, SHIFT, DONE).
  - Function pow10(n) for the elaboration-time overflow constant.
  - Constant BCD_NINE=4'h9.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, adds 3 when in >= 5. Instantiated DIGITS+1 times via generate.

Test Plan:
- WIDTH=12, DIGITS=4, bin_i=0 -> valid_o after 14 cycles, bcd_o=16'h0000, ovf_o=0, blank_o=4'b1110 (with macro).
- bin_i=4095 -> bcd_o=16'h4095, ovf_o=0, busy_o high for exactly 12 cycles.
- WIDTH=14, DIGITS=4:
  - bin_i=9999 -> bcd_o=16'h9999, ovf_o=0.
  - bin_i=10000 -> bcd_o=16'h9999, ovf_o=1.
- bin_i=42, then start_i pulsed with bin_i=7 while busy -> single valid_o, bcd_o=16'h0042, blank_o=4'b1100; a second start_i in the valid_o cycle with bin_i=7 -> next result 16'h0007.
- rst_i asserted 5 cycles into conversion of 1234 -> no valid_o, bcd_o=0, busy_o=0 next cycle; new start with 1234 -> 16'h1234.
- Randomised back-to-back conversions of 1000 values are compared against a reference model, and valid_o timing is checked every time.
